// File: rtl/td4_core.sv
// ============================================================================
// Module   : td4_core
// Purpose  : 4-bit single-cycle TD4 processor core driving a 16x8 program ROM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module td4_core #(
    parameter logic [3:0] RESET_PC = 4'h0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [3:0] rom_addr,
    input  logic [7:0] rom_data,
    input  logic [3:0] in_port,
    output logic [3:0] out_port,
    output logic [3:0] reg_a,
    output logic [3:0] reg_b,
    output logic       carry
);

    localparam logic [3:0] c_OP_ADD_A  = 4'b0000;
    localparam logic [3:0] c_OP_MOV_AB = 4'b0001;
    localparam logic [3:0] c_OP_IN_A   = 4'b0010;
    localparam logic [3:0] c_OP_MOV_AI = 4'b0011;
    localparam logic [3:0] c_OP_MOV_BA = 4'b0100;
    localparam logic [3:0] c_OP_ADD_B  = 4'b0101;
    localparam logic [3:0] c_OP_IN_B   = 4'b0110;
    localparam logic [3:0] c_OP_MOV_BI = 4'b0111;
    localparam logic [3:0] c_OP_OUT_B  = 4'b1001;
    localparam logic [3:0] c_OP_OUT_I  = 4'b1011;
    localparam logic [3:0] c_OP_JNC    = 4'b1110;
    localparam logic [3:0] c_OP_JMP    = 4'b1111;

    logic [3:0] pc_q, pc_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic [3:0] out_q, out_d;
    logic       carry_q, carry_d;

    logic [3:0] w_opcode;
    logic [3:0] w_imm;
    logic [4:0] w_sum_a;
    logic [4:0] w_sum_b;

    assign w_opcode = rom_data[7:4];
    assign w_imm    = rom_data[3:0];
    assign w_sum_a  = {1'b0, a_q} + {1'b0, w_imm};
    assign w_sum_b  = {1'b0, b_q} + {1'b0, w_imm};

    // Carry defaults to 0: only ADD leaves a non-zero carry behind.
    always_comb begin
        pc_d    = pc_q + 4'd1;
        a_d     = a_q;
        b_d     = b_q;
        out_d   = out_q;
        carry_d = 1'b0;
        case (w_opcode)
            c_OP_ADD_A: begin
                a_d     = w_sum_a[3:0];
                carry_d = w_sum_a[4];
            end
            c_OP_ADD_B: begin
                b_d     = w_sum_b[3:0];
                carry_d = w_sum_b[4];
            end
            c_OP_MOV_AI: a_d   = w_imm;
            c_OP_MOV_BI: b_d   = w_imm;
            c_OP_MOV_AB: a_d   = b_q;
            c_OP_MOV_BA: b_d   = a_q;
            c_OP_IN_A:   a_d   = in_port;
            c_OP_IN_B:   b_d   = in_port;
            c_OP_OUT_B:  out_d = b_q;
            c_OP_OUT_I:  out_d = w_imm;
            c_OP_JMP:    pc_d  = w_imm;
            c_OP_JNC: begin
                if (!carry_q) begin
                    pc_d = w_imm;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            a_q     <= 4'h0;
            b_q     <= 4'h0;
            out_q   <= 4'h0;
            carry_q <= 1'b0;
        end else if (en) begin
            pc_q    <= pc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            out_q   <= out_d;
            carry_q <= carry_d;
        end
    end

    assign rom_addr = pc_q;
    assign out_port = out_q;
    assign reg_a    = a_q;
    assign reg_b    = b_q;
    assign carry    = carry_q;

endmodule

`default_nettype wire
